// File: rtl/complex_nr_acc_pkg.sv
// Shared definitions for the complex dot-product accumulator: state
// encoding, accumulator width derivation and lane sign extension.
package complex_nr_acc_pkg;

    localparam logic ST_ACCUM  = 1'b0;
    localparam logic ST_OUTPUT = 1'b1;

    typedef enum logic {
        S_ACCUM  = ST_ACCUM,
        S_OUTPUT = ST_OUTPUT
    } state_e;

    // Product width is twice the multiplier operand width; guard bits absorb growth.
    function automatic int acc_width(input int data_width, input int guard_bits);
        return 2 * data_width + guard_bits;
    endfunction

    // Sign-extends the low from_width bits of value to 64 bits; callers
    // truncate the result to their accumulator width.
    function automatic logic [63:0] sign_extend(input logic [63:0] value, input int from_width);
        logic signed [63:0] shifted;
        shifted = $signed(value << (64 - from_width));
        return $unsigned(shifted >>> (64 - from_width));
    endfunction

endpackage

// File: rtl/complex_acc_lane.sv
// One lane (real or imaginary) of the complex accumulator: a wrapping
// signed running sum plus the register that holds the finished sum.
module complex_acc_lane
    import complex_nr_acc_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 sw_rst,
    input  logic                 clr,       // first sample of a run: ignore the held sum
    input  logic                 add_en,    // a sample is accepted this cycle
    input  logic                 load_out,  // last sample of a run: publish and restart
    input  logic [IN_WIDTH-1:0]  din,
    output logic [ACC_WIDTH-1:0] dout
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] din_ext;
    logic [ACC_WIDTH-1:0] sum;

    assign din_ext = ACC_WIDTH'(sign_extend(64'(din), IN_WIDTH));
    // Wraps modulo 2**ACC_WIDTH by construction; no saturation.
    assign sum     = (clr ? '0 : acc) + din_ext;

    // Running sum and published sum; the finished sum holds until the next run completes.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement or process order.
        if (!rstn) begin
            acc  <= '0;
            dout <= '0;
        end else if (sw_rst) begin
            acc  <= '0;
            dout <= '0;
        end else if (add_en) begin
            if (load_out) begin
                dout <= sum;
                acc  <= '0;
            end else begin
                acc  <= sum;
            end
        end
    end

endmodule

// File: rtl/complex_nr_acc.sv
// Complex dot-product accumulator behind the complex multiplier. Sums a
// run of acc_len products and presents the sum over a valid/ready port,
// back-pressuring the multiplier while the sum waits to be taken.
module complex_nr_acc
    import complex_nr_acc_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int GUARD_BITS = 4,
    parameter  int LEN_WIDTH  = 4,
    localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, GUARD_BITS)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    sw_rst,
    input  logic                    in_val,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] in_re,
    input  logic [2*DATA_WIDTH-1:0] in_im,
    input  logic [LEN_WIDTH-1:0]    acc_len,
    output logic                    out_val,
    input  logic                    out_ready,
    output logic [ACC_WIDTH-1:0]    out_re,
    output logic [ACC_WIDTH-1:0]    out_im,
    output logic [LEN_WIDTH-1:0]    run_cnt
);

    state_e               state;
    state_e               state_next;
    logic [LEN_WIDTH-1:0] len_reg;
    logic [LEN_WIDTH-1:0] eff_len;
    logic                 first;
    logic                 last;
    logic                 accept;

    assign accept = in_val & in_ready;
    assign first  = (run_cnt == '0);

    // On the first accept the run length comes straight from acc_len (0 means 1),
    // so a length-1 run can finish on that same accept.
    assign eff_len = first ? ((acc_len == '0) ? LEN_WIDTH'(1) : acc_len) : len_reg;
    assign last    = ((LEN_WIDTH + 1)'(run_cnt) + (LEN_WIDTH + 1)'(1)) >= (LEN_WIDTH + 1)'(eff_len);

    // State register; software reset wins over any handshake in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_ACCUM;
        end else if (sw_rst) begin
            state <= S_ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        // NOTE: every output is given a default before the case so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_next = state;
        in_ready   = 1'b0;
        out_val    = 1'b0;
        case (state)
            S_ACCUM: begin
                in_ready = 1'b1;
                if (in_val && last) begin
                    state_next = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                out_val = 1'b1;
                if (out_ready) begin
                    state_next = S_ACCUM;
                end
            end
        endcase
    end

    // Run counter and latched run length; length changes mid-run are ignored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_cnt <= '0;
            len_reg <= '0;
        end else if (sw_rst) begin
            run_cnt <= '0;
            len_reg <= '0;
        end else if (accept) begin
            if (first) begin
                len_reg <= eff_len;
            end
            run_cnt <= last ? '0 : run_cnt + LEN_WIDTH'(1);
        end
    end

    complex_acc_lane #(
        .IN_WIDTH  (2 * DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_lane_re (
        .clk      (clk),
        .rstn     (rstn),
        .sw_rst   (sw_rst),
        .clr      (first),
        .add_en   (accept),
        .load_out (last),
        .din      (in_re),
        .dout     (out_re)
    );

    complex_acc_lane #(
        .IN_WIDTH  (2 * DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_lane_im (
        .clk      (clk),
        .rstn     (rstn),
        .sw_rst   (sw_rst),
        .clr      (first),
        .add_en   (accept),
        .load_out (last),
        .din      (in_im),
        .dout     (out_im)
    );

endmodule

// File: tb/tb_complex_nr_acc.sv
// Self-checking bench for complex_nr_acc (DATA_WIDTH=8, GUARD_BITS=4, LEN_WIDTH=4).
module tb_complex_nr_acc;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sw_rst = 1'b0;
    logic        in_val = 1'b0;
    logic        in_ready;
    logic [15:0] in_re = '0;
    logic [15:0] in_im = '0;
    logic [3:0]  acc_len = '0;
    logic        out_val;
    logic        out_ready = 1'b0;
    logic [19:0] out_re;
    logic [19:0] out_im;
    logic [3:0]  run_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    complex_nr_acc #(
        .DATA_WIDTH (8),
        .GUARD_BITS (4),
        .LEN_WIDTH  (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sw_rst    (sw_rst),
        .in_val    (in_val),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .acc_len   (acc_len),
        .out_val   (out_val),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .run_cnt   (run_cnt)
    );

    // Reference: a run's sum is the plain integer sum of its signed products, wrapped to 20 bits.
    function automatic logic [19:0] model_sum(input int vals[$]);
        int s = 0;
        foreach (vals[i]) s += vals[i];
        return 20'(s);
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one product and return just after the edge that accepted it.
    task automatic send(input logic [15:0] re, input logic [15:0] im, input logic [3:0] len);
        in_re = re;
        in_im = im;
        acc_len = len;
        in_val = 1'b1;
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        if (!in_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: in_ready got %b required 1", in_ready);
        end
        tick();
        in_val = 1'b0;
    endtask

    task automatic wait_out();
        for (int i = 0; i < 200 && !out_val; i++) tick();
        if (!out_val) begin
            tests_run++;
            tests_failed++;
            $display("FAIL out_timeout: out_val got %b required 1", out_val);
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        tick();
        tests_run++;
        if ({out_val, in_ready, run_cnt, out_re, out_im} !== {1'b0, 1'b1, 4'd0, 20'd0, 20'd0}) begin
            tests_failed++;
            $display("FAIL reset_state: got val=%b rdy=%b cnt=%0d re=%h im=%h required 0 1 0 0 0",
                     out_val, in_ready, run_cnt, out_re, out_im);
        end
    endtask

    task automatic test_basic();
        send(16'd1, 16'd2, 4'd4);
        send(16'd3, 16'd4, 4'd4);
        send(16'd5, 16'd6, 4'd4);
        tests_run++;
        if ({out_val, run_cnt} !== {1'b0, 4'd3}) begin
            tests_failed++;
            $display("FAIL basic_mid: got val=%b cnt=%0d required 0 3", out_val, run_cnt);
        end
        send(16'd7, 16'd8, 4'd4);
        tests_run++;
        if ({out_val, run_cnt, out_re, out_im} !== {1'b1, 4'd0, 20'd16, 20'd20}) begin
            tests_failed++;
            $display("FAIL basic_sum: got val=%b cnt=%0d re=%0d im=%0d required 1 0 16 20",
                     out_val, run_cnt, out_re, out_im);
        end
        take();
        tests_run++;
        if (out_val !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_drop: out_val got %b required 0", out_val);
        end
    endtask

    task automatic test_negative();
        repeat (4) send(16'hFFFF, 16'h8000, 4'd4);
        wait_out();
        tests_run++;
        if ({out_re, out_im} !== {20'hFFFFC, 20'hE0000}) begin
            tests_failed++;
            $display("FAIL negative_sum: got re=%h im=%h required FFFFC E0000", out_re, out_im);
        end
        take();
    endtask

    task automatic test_back_pressure();
        send(16'd3, 16'd4, 4'd2);
        send(16'd5, 16'd6, 4'd2);
        in_val = 1'b1;
        in_re = 16'h1111;
        in_im = 16'h2222;
        for (int c = 0; c < 5; c++) begin
            tick();
            tests_run++;
            if ({in_ready, out_val, out_re, out_im} !== {1'b0, 1'b1, 20'd8, 20'd10}) begin
                tests_failed++;
                $display("FAIL back_pressure_hold: cycle %0d got rdy=%b val=%b re=%0d im=%0d required 0 1 8 10",
                         c, in_ready, out_val, out_re, out_im);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_val = 1'b0;
        tests_run++;
        if ({out_val, in_ready, run_cnt, out_re, out_im} !== {1'b0, 1'b1, 4'd0, 20'd8, 20'd10}) begin
            tests_failed++;
            $display("FAIL back_pressure_release: got val=%b rdy=%b cnt=%0d re=%0d im=%0d required 0 1 0 8 10",
                     out_val, in_ready, run_cnt, out_re, out_im);
        end
    endtask

    task automatic test_len_zero();
        send(16'd5, 16'hFFFD, 4'd0);
        tests_run++;
        if ({out_val, out_re, out_im} !== {1'b1, 20'd5, 20'hFFFFD}) begin
            tests_failed++;
            $display("FAIL len_zero_first: got val=%b re=%h im=%h required 1 00005 FFFFD", out_val, out_re, out_im);
        end
        take();
        send(16'd7, 16'd9, 4'd0);
        tests_run++;
        if ({out_val, out_re, out_im} !== {1'b1, 20'd7, 20'd9}) begin
            tests_failed++;
            $display("FAIL len_zero_second: got val=%b re=%h im=%h required 1 00007 00009", out_val, out_re, out_im);
        end
        take();
    endtask

    task automatic test_sw_rst();
        send(16'd10, 16'd10, 4'd4);
        send(16'd20, 16'd20, 4'd4);
        // Soft reset coincides with an offered product; the reset must win.
        sw_rst = 1'b1;
        in_val = 1'b1;
        in_re = 16'd100;
        in_im = 16'd100;
        tick();
        sw_rst = 1'b0;
        in_val = 1'b0;
        tests_run++;
        if ({run_cnt, out_val} !== {4'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL sw_rst_run: got cnt=%0d val=%b required 0 0", run_cnt, out_val);
        end
        repeat (4) send(16'd1, 16'd1, 4'd4);
        tests_run++;
        if ({out_val, out_re, out_im} !== {1'b1, 20'd4, 20'd4}) begin
            tests_failed++;
            $display("FAIL sw_rst_sum: got val=%b re=%0d im=%0d required 1 4 4", out_val, out_re, out_im);
        end
        sw_rst = 1'b1;
        out_ready = 1'b1;
        tick();
        sw_rst = 1'b0;
        out_ready = 1'b0;
        tests_run++;
        if ({out_val, in_ready, out_re, out_im} !== {1'b0, 1'b1, 20'd0, 20'd0}) begin
            tests_failed++;
            $display("FAIL sw_rst_output: got val=%b rdy=%b re=%0d im=%0d required 0 1 0 0",
                     out_val, in_ready, out_re, out_im);
        end
    endtask

    task automatic test_async_reset();
        send(16'd9, 16'd9, 4'd1);
        tests_run++;
        if ({out_val, out_re} !== {1'b1, 20'd9}) begin
            tests_failed++;
            $display("FAIL async_pre: got val=%b re=%0d required 1 9", out_val, out_re);
        end
        #2 rstn = 1'b0;
        #1;
        tests_run++;
        if ({out_val, out_re, out_im} !== {1'b0, 20'd0, 20'd0}) begin
            tests_failed++;
            $display("FAIL async_reset: got val=%b re=%0d im=%0d required 0 0 0", out_val, out_re, out_im);
        end
        #2 rstn = 1'b1;
        tick();
        tests_run++;
        if ({in_ready, run_cnt} !== {1'b1, 4'd0}) begin
            tests_failed++;
            $display("FAIL async_post: got rdy=%b cnt=%0d required 1 0", in_ready, run_cnt);
        end
    endtask

    task automatic test_len_change();
        send(16'd1, 16'd0, 4'd2);
        send(16'd2, 16'd0, 4'd3);
        tests_run++;
        if ({out_val, out_re} !== {1'b1, 20'd3}) begin
            tests_failed++;
            $display("FAIL len_change_first: got val=%b re=%0d required 1 3", out_val, out_re);
        end
        take();
        send(16'd1, 16'd1, 4'd3);
        send(16'd1, 16'd1, 4'd1);
        tests_run++;
        if ({out_val, run_cnt} !== {1'b0, 4'd2}) begin
            tests_failed++;
            $display("FAIL len_change_mid: got val=%b cnt=%0d required 0 2", out_val, run_cnt);
        end
        send(16'd1, 16'd1, 4'd7);
        tests_run++;
        if ({out_val, out_re, out_im} !== {1'b1, 20'd3, 20'd3}) begin
            tests_failed++;
            $display("FAIL len_change_second: got val=%b re=%0d im=%0d required 1 3 3", out_val, out_re, out_im);
        end
        take();
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            int          len;
            int          eff;
            int          q_re[$];
            int          q_im[$];
            logic [19:0] exp_re;
            logic [19:0] exp_im;
            len = $urandom_range(0, 15);
            eff = (len == 0) ? 1 : len;
            q_re.delete();
            q_im.delete();
            for (int k = 0; k < eff; k++) begin
                logic [15:0] re;
                logic [15:0] im;
                re = 16'($urandom);
                im = 16'($urandom);
                q_re.push_back($signed(re));
                q_im.push_back($signed(im));
                repeat ($urandom_range(0, 2)) tick();
                send(re, im, (k == 0) ? 4'(len) : 4'($urandom));
                if (k < eff - 1) begin
                    tests_run++;
                    if ({out_val, run_cnt} !== {1'b0, 4'(k + 1)}) begin
                        tests_failed++;
                        $display("FAIL random_count: run %0d got val=%b cnt=%0d required 0 %0d",
                                 r, out_val, run_cnt, k + 1);
                    end
                end
            end
            exp_re = model_sum(q_re);
            exp_im = model_sum(q_im);
            tests_run++;
            if ({out_val, out_re, out_im} !== {1'b1, exp_re, exp_im}) begin
                tests_failed++;
                $display("FAIL random_sum: run %0d len %0d got val=%b re=%h im=%h required 1 %h %h",
                         r, len, out_val, out_re, out_im, exp_re, exp_im);
            end
            repeat ($urandom_range(0, 3)) begin
                in_val = 1'($urandom);
                in_re = 16'($urandom);
                tick();
                tests_run++;
                if ({out_val, in_ready, out_re, out_im} !== {1'b1, 1'b0, exp_re, exp_im}) begin
                    tests_failed++;
                    $display("FAIL random_stall: run %0d got val=%b rdy=%b re=%h im=%h required 1 0 %h %h",
                             r, out_val, in_ready, out_re, out_im, exp_re, exp_im);
                end
            end
            in_val = 1'b0;
            take();
            tests_run++;
            if (out_val !== 1'b0) begin
                tests_failed++;
                $display("FAIL random_drop: run %0d out_val got %b required 0", r, out_val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_back_pressure();
        test_len_zero();
        test_sw_rst();
        test_async_reset();
        test_len_change();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
